branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Consumes 16-bit comparator flags (gt/eq of A vs B) and branch info; resolves taken/not-taken.
//  Computes the branch target and flags mispredicts against the fetch prediction.
//  Sits directly downstream of the comparator, between execute and the fetch redirect logic.
//  Results are registered into a 2-entry output FIFO with valid/ready on both sides.
// PARAMETERS
//  WIDTH  16  data/PC width (comparator operand width, target adder width)
// PORTS
//  clk              in   1      clock; all state updates on posedge
//  rst              in   1      synchronous reset, active-high
//  in_valid         in   1      upstream presents a branch to resolve
//  in_ready         out  1      unit can accept; = (count < 2) && !rst; independent of out_ready
//  cond             in   3      0 EQ,1 NE,2 GT,3 LT,4 GE,5 LE,6 ALWAYS,7 NEVER
//  cmp_gt           in   1      comparator: A > B (unsigned, as produced upstream)
//  cmp_eq           in   1      comparator: A == B
//  pred_taken       in   1      fetch-stage prediction for this branch
//  pc_plus2         in   WIDTH  PC of the instruction after the branch
//  imm              in   WIDTH  sign-extended branch offset
//  flush            in   1      discard all buffered and incoming entries
//  out_valid        out  1      head entry valid
//  out_ready        in   1      downstream consumes head entry
//  out_taken        out  1      resolved direction of head entry
//  out_mispredict   out  1      out_taken != pred_taken of head entry
//  out_redirect_pc  out  WIDTH  out_taken ? target : pc_plus2 of head entry
// BEHAVIOUR
//  - Resolution: lt = !cmp_gt && !cmp_eq; taken per cond: EQ=eq, NE=!eq, GT=gt, LT=lt,
//    GE=gt|eq, LE=lt|eq, ALWAYS=1, NEVER=0. cmp_gt&&cmp_eq together is illegal; GT/GE/LE then follow the literal eq/gt formulas.
//  - target = pc_plus2 + imm, WIDTH-bit, wraps modulo 2^WIDTH (ffff+0002 -> 0001); no overflow flag.
//  - All resolution math computed at accept; entry stores {taken, mispredict, redirect_pc}.
//  - Accept: in_valid && in_ready at edge N -> entry visible on outputs in cycle N+1 (latency 1).
//  - Pop: out_valid && out_ready at edge. Outputs are FIFO head, order preserved.
//  - Occupancy FSM: EMPTY(0) / ONE(1) / TWO(2).
//      EMPTY: push -> ONE; else stay.
//      ONE: push&pop -> ONE (new entry becomes head next cycle); push -> TWO; pop -> EMPTY.
//      TWO: in_ready=0; pop -> ONE; else stay.
//  - flush at edge: next state EMPTY; same-cycle in_valid is dropped, same-cycle pop is void.
//  - rst at edge (even mid-transfer): state EMPTY; out_valid=0, out_taken=0, out_mispredict=0,
//    out_redirect_pc=0, in_ready=0 while rst high, 1 the cycle after. rst has priority over flush.
//  - When out_valid=0, out_taken/out_mispredict/out_redirect_pc are driven 0 (not stale).
//  - Holding out_valid with out_ready=0: head outputs stable until popped.
// CONFIGURATION
//  BRU_STATS_EN defined: adds outputs stat_branches[15:0], stat_mispred[15:0];
//    stat_branches +1 per pop, stat_mispred +1 per pop with mispredict; both saturate at ffff;
//    cleared by rst only (not flush).
//  BRU_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. rst high 2 cycles -> out_valid=0, in_ready=0 during, in_ready=1 after, outputs 0.
//  2. cond=GT, gt=1,eq=0, pc_plus2=0010, imm=0006, pred=0 -> next cycle taken=1, mispredict=1, redirect=0016.
//  3. cond=LE, gt=0,eq=0, pc_plus2=fffe, imm=0004, pred=1 -> taken=1, mispredict=0, redirect=0002 (wrap).
//  4. out_ready=0, push 3 back-to-back -> in_ready=0 after 2nd; then out_ready=1 -> pop order 1,2, 3rd accepted after.
//  5. Two entries buffered, flush with in_valid=1 -> next cycle out_valid=0, nothing from that input appears.
//  6. BRU_STATS_EN: 5 pops, 2 mispredicted -> stat_branches=5, stat_mispred=2; flush keeps them.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: turns comparator flags + branch info into {taken, mispredict, redirect_pc}
// and buffers results in a 2-entry valid/ready FIFO. Optional BRU_STATS_EN adds pop/mispredict counters.
module branch_resolve_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cond,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             pred_taken,
    input  logic [WIDTH-1:0] pc_plus2,
    input  logic [WIDTH-1:0] imm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic [WIDTH-1:0] out_redirect_pc
`ifdef BRU_STATS_EN
    ,
    output logic [15:0]      stat_branches,
    output logic [15:0]      stat_mispred
`endif
);

    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_GT     = 3'd2;
    localparam logic [2:0] COND_LT     = 3'd3;
    localparam logic [2:0] COND_GE     = 3'd4;
    localparam logic [2:0] COND_LE     = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    typedef struct packed {
        logic             taken;
        logic             mispredict;
        logic [WIDTH-1:0] redirect_pc;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    entry_t           slot0;
    entry_t           slot1;
    entry_t           slot0_d;
    entry_t           slot1_d;
    entry_t           new_entry;
    logic             lt;
    logic             taken;
    logic [WIDTH-1:0] target;
    logic             push;
    logic             pop;

    // Resolve direction and redirect target for the incoming branch
    assign lt     = !cmp_gt && !cmp_eq;
    assign target = pc_plus2 + imm;

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ:     taken = cmp_eq;
            COND_NE:     taken = !cmp_eq;
            COND_GT:     taken = cmp_gt;
            COND_LT:     taken = lt;
            COND_GE:     taken = cmp_gt | cmp_eq;
            COND_LE:     taken = lt | cmp_eq;
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

    always_comb begin
        new_entry.taken       = taken;
        new_entry.mispredict  = taken ^ pred_taken;
        new_entry.redirect_pc = taken ? target : pc_plus2;
    end

    // Handshakes; flush voids both sides in the same cycle
    assign in_ready  = !rst && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Head entry lives in slot0, which is kept zero while empty
    assign out_taken       = slot0.taken;
    assign out_mispredict  = slot0.mispredict;
    assign out_redirect_pc = slot0.redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            state <= state_d;
            slot0 <= slot0_d;
            slot1 <= slot1_d;
        end
    end

    // Occupancy next-state and slot update
    always_comb begin
        state_d = state;
        slot0_d = slot0;
        slot1_d = slot1;
        if (flush) begin
            state_d = EMPTY;
            slot0_d = '0;
            slot1_d = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        slot0_d = new_entry;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        slot0_d = new_entry;
                    end else if (push) begin
                        state_d = TWO;
                        slot1_d = new_entry;
                    end else if (pop) begin
                        state_d = EMPTY;
                        slot0_d = '0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        slot0_d = slot1;
                        slot1_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    slot0_d = '0;
                    slot1_d = '0;
                end
            endcase
        end
    end

`ifdef BRU_STATS_EN
    // Saturating pop counters; survive flush, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (pop) begin
            if (stat_branches != 16'hffff) begin
                stat_branches <= stat_branches + 16'd1;
            end
            if (slot0.mispredict && (stat_mispred != 16'hffff)) begin
                stat_mispred <= stat_mispred + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; exercises stats counters when BRU_STATS_EN is defined.
module tb_branch_resolve_unit;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       cond;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             pred_taken;
    logic [WIDTH-1:0] pc_plus2;
    logic [WIDTH-1:0] imm;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_mispredict;
    logic [WIDTH-1:0] out_redirect_pc;
`ifdef BRU_STATS_EN
    logic [15:0]      stat_branches;
    logic [15:0]      stat_mispred;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .cond            (cond),
        .cmp_gt          (cmp_gt),
        .cmp_eq          (cmp_eq),
        .pred_taken      (pred_taken),
        .pc_plus2        (pc_plus2),
        .imm             (imm),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_taken       (out_taken),
        .out_mispredict  (out_mispredict),
        .out_redirect_pc (out_redirect_pc)
`ifdef BRU_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
`endif
    );

    typedef struct {
        logic [2:0]  cond;
        logic        gt;
        logic        eq;
        logic        pred;
        logic [15:0] pc;
        logic [15:0] imm;
        logic        exp_taken;
        logic        exp_misp;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic v, input logic t, input logic m,
                              input logic [15:0] pc);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".taken"}, 32'(out_taken), 32'(t));
        check({tag, ".misp"},  32'(out_mispredict), 32'(m));
        check({tag, ".pc"},    32'(out_redirect_pc), 32'(pc));
    endtask

    task automatic drive(input logic [2:0] c, input logic g, input logic e, input logic p,
                         input logic [15:0] pc, input logic [15:0] im);
        cond       = c;
        cmp_gt     = g;
        cmp_eq     = e;
        pred_taken = p;
        pc_plus2   = pc;
        imm        = im;
    endtask

    task automatic push_one(input logic [2:0] c, input logic g, input logic e, input logic p,
                            input logic [15:0] pc, input logic [15:0] im);
        drive(c, g, e, p, pc, im);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'd0, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0010, 1'b0, 1'b0, 16'h1000};
        vecs[1] = '{3'd1, 1'b1, 1'b0, 1'b0, 16'h1000, 16'hfff0, 1'b1, 1'b1, 16'h0ff0};
        vecs[2] = '{3'd2, 1'b0, 1'b1, 1'b1, 16'h2000, 16'h0002, 1'b0, 1'b1, 16'h2000};
        vecs[3] = '{3'd3, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h0100, 1'b1, 1'b0, 16'h3100};
        vecs[4] = '{3'd3, 1'b1, 1'b0, 1'b0, 16'h3000, 16'h0100, 1'b0, 1'b0, 16'h3000};
        vecs[5] = '{3'd4, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h8000, 1'b1, 1'b1, 16'hc000};
        vecs[6] = '{3'd4, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h8000, 1'b0, 1'b1, 16'h4000};
        vecs[7] = '{3'd5, 1'b1, 1'b0, 1'b0, 16'h5000, 16'h0040, 1'b0, 1'b0, 16'h5000};
        vecs[8] = '{3'd2, 1'b1, 1'b1, 1'b1, 16'hffff, 16'h0002, 1'b1, 1'b0, 16'h0001};
        vecs[9] = '{3'd7, 1'b1, 1'b1, 1'b0, 16'h6000, 16'h0010, 1'b0, 1'b0, 16'h6000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        // reset held two cycles
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst.in_ready", 32'(in_ready), 32'd0);
            check_head("rst", 1'b0, 1'b0, 1'b0, 16'h0000);
        end
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);
        check_head("post_rst", 1'b0, 1'b0, 1'b0, 16'h0000);

        // GT taken, mispredicted
        push_one(3'd2, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0006);
        check_head("gt", 1'b1, 1'b1, 1'b1, 16'h0016);
        check("gt.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_head("gt_pop", 1'b0, 1'b0, 1'b0, 16'h0000);

        // LE via lt, target wraps
        push_one(3'd5, 1'b0, 1'b0, 1'b1, 16'hfffe, 16'h0004);
        check_head("le_wrap", 1'b1, 1'b1, 1'b0, 16'h0002);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // condition table
        foreach (vecs[i]) begin
            push_one(vecs[i].cond, vecs[i].gt, vecs[i].eq, vecs[i].pred, vecs[i].pc, vecs[i].imm);
            check_head($sformatf("vec%0d", i), 1'b1, vecs[i].exp_taken, vecs[i].exp_misp, vecs[i].exp_pc);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check_head("table_drained", 1'b0, 1'b0, 1'b0, 16'h0000);

        // back-pressure: three back-to-back pushes with out_ready low
        drive(3'd6, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0010);
        in_valid = 1'b1;
        step();
        check("bp.ready_after1", 32'(in_ready), 32'd1);
        drive(3'd7, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0004);
        step();
        check("bp.ready_after2", 32'(in_ready), 32'd0);
        drive(3'd0, 1'b0, 1'b1, 1'b0, 16'h0300, 16'h0020);
        step();
        check("bp.ready_held", 32'(in_ready), 32'd0);
        check_head("bp.hold", 1'b1, 1'b1, 1'b0, 16'h0110);
        out_ready = 1'b1;
        step();
        check_head("bp.second", 1'b1, 1'b0, 1'b1, 16'h0200);
        check("bp.ready_one", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_head("bp.third", 1'b1, 1'b1, 1'b1, 16'h0320);
        step();
        out_ready = 1'b0;
        check_head("bp.drained", 1'b0, 1'b0, 1'b0, 16'h0000);

        // flush with two buffered and an incoming branch
        push_one(3'd6, 1'b0, 1'b0, 1'b0, 16'h0400, 16'h0002);
        push_one(3'd6, 1'b0, 1'b0, 1'b0, 16'h0500, 16'h0002);
        check("fl2.full", 32'(in_ready), 32'd0);
        drive(3'd6, 1'b0, 1'b0, 1'b0, 16'h0600, 16'h0002);
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check_head("fl2", 1'b0, 1'b0, 1'b0, 16'h0000);
        check("fl2.in_ready", 32'(in_ready), 32'd1);
        step();
        check("fl2.nothing", 32'(out_valid), 32'd0);

        // flush with one buffered: acceptable input and pop both dropped
        push_one(3'd6, 1'b0, 1'b0, 1'b0, 16'h0700, 16'h0002);
        drive(3'd6, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0002);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        check_head("fl1", 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        check("fl1.nothing", 32'(out_valid), 32'd0);

        // reset mid-transfer beats flush
        push_one(3'd6, 1'b0, 1'b0, 1'b1, 16'h0900, 16'h0002);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        rst       = 1'b1;
        #1;
        check("rst_mid.in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        check_head("rst_mid", 1'b0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        #1;
        check("rst_mid.after", 32'(in_ready), 32'd1);

`ifdef BRU_STATS_EN
        check("stats.clr_b", 32'(stat_branches), 32'd0);
        check("stats.clr_m", 32'(stat_mispred), 32'd0);
        for (int i = 0; i < 5; i++) begin
            push_one(3'd6, 1'b0, 1'b0, (i == 1 || i == 3) ? 1'b0 : 1'b1, 16'h0a00, 16'h0002);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        push_one(3'd6, 1'b0, 1'b0, 1'b0, 16'h0b00, 16'h0002);
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        out_ready = 1'b0;
        flush     = 1'b0;
        check("stats.branches", 32'(stat_branches), 32'd5);
        check("stats.mispred", 32'(stat_mispred), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
